// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FSM states and IF/ID register layout for the fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR = 32'h0000_006F;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;
  localparam if_id_t BUBBLE = '{pc: 64'h0, instr: NOP_INSTR, valid: 1'b0};
endpackage

// File: rtl/if_id_pipeline_reg.sv
// if_id_pipeline_reg: IF/ID register with bubble (highest priority), load and hold
module if_id_pipeline_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= BUBBLE;
    else if (bubble) q <= BUBBLE;
    else if (load) q <= d;
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: RV64 IF stage owning the PC, redirect/stall/flush, halt detect and range fault
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          IMEM_BYTES  = 128,
  parameter bit          HALT_DETECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [63:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic        fetch_fault_o,
  output logic [31:0] fetch_count_o
);
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;
  fetch_state_t state, state_n;
  logic [63:0] pc, pc_n;
  logic [31:0] count, count_n;
  logic fault, fault_n, ld, bub, is_halt;
  if_id_t if_id_q;
  assign is_halt = HALT_DETECT && (imem_rdata_i == HALT_INSTR);
  always_comb begin
    state_n = state;
    pc_n = pc;
    count_n = count;
    fault_n = fault;
    ld = 1'b0;
    bub = 1'b0;
    if (state == BOOT) begin
      state_n = RUN;
      bub = 1'b1;
    end else if (redirect_valid_i) begin
      pc_n = {redirect_pc_i[63:2], 2'b00};
      state_n = RUN;
      bub = 1'b1;
    end else if (state == HALT || flush_i) begin
      bub = 1'b1;
    end else if (!stall_i) begin
      if (pc > LAST_PC) begin
        bub = 1'b1;
        fault_n = 1'b1;
      end else begin
        ld = 1'b1;
        count_n = &count ? count : count + 32'd1;
        pc_n = is_halt ? pc : pc + 64'd4;
        state_n = is_halt ? HALT : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      count <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      count <= count_n;
      fault <= fault_n;
    end
  if_id_pipeline_reg u_if_id (
    .clk(clk),
    .rst_n(rst_n),
    .load(ld),
    .bubble(bub),
    .d('{pc: pc, instr: imem_rdata_i, valid: 1'b1}),
    .q(if_id_q)
  );
  assign imem_addr_o = pc;
  assign if_id_pc_o = if_id_q.pc;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;
  assign halted_o = (state == HALT);
  assign fetch_fault_o = fault;
  assign fetch_count_o = count;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed-vector bench for instruction_fetch_stage
module tb_instruction_fetch_stage;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, redir = 1'b0;
  logic [63:0] redir_pc = '0, imem_addr, if_id_pc;
  logic [31:0] imem_rdata, if_id_instr, fetch_count;
  logic if_id_valid, halted, fault;
  logic [31:0] mem [32];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign imem_rdata = (imem_addr < 64'd128) ? mem[imem_addr[6:2]] : 32'h0000_0013;

  instruction_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .if_id_pc_o(if_id_pc), .if_id_instr_o(if_id_instr), .if_id_valid_o(if_id_valid),
    .halted_o(halted), .fetch_fault_o(fault), .fetch_count_o(fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h0, 32'h13, 1'b0}) begin errors++; $display("FAIL rst_ifid got %h %h %b", if_id_pc, if_id_instr, if_id_valid); end
    checks++; if ({halted, fault, fetch_count} !== 34'h0) begin errors++; $display("FAIL rst_flags got %b %b %h want 0", halted, fault, fetch_count); end
    rst_n = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL boot_bubble got v=%b addr=%h want 0/0", if_id_valid, imem_addr); end
    step();
    checks++; if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h0, 32'h00A00093, 1'b1}) begin errors++; $display("FAIL first_fetch got %h %h %b", if_id_pc, if_id_instr, if_id_valid); end
    checks++; if (imem_addr !== 64'h4 || fetch_count !== 32'd1) begin errors++; $display("FAIL first_fetch_pc got %h cnt %0d want 4/1", imem_addr, fetch_count); end
  endtask

  task automatic test_stall();
    repeat (9) step();
    checks++; if (imem_addr !== 64'h28 || fetch_count !== 32'd10) begin errors++; $display("FAIL seq_run got %h cnt %0d want 28/10", imem_addr, fetch_count); end
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (imem_addr !== 64'h28 || if_id_pc !== 64'h24 || if_id_valid !== 1'b1 || fetch_count !== 32'd10) begin errors++; $display("FAIL stall_hold got %h %h %b %0d want 28 24 1 10", imem_addr, if_id_pc, if_id_valid, fetch_count); end
    end
    stall = 1'b0;
    step();
    checks++; if (if_id_pc !== 64'h28 || if_id_instr !== 32'h00A00013 || imem_addr !== 64'h2C) begin errors++; $display("FAIL stall_release got %h %h %h want 28 00a00013 2c", if_id_pc, if_id_instr, imem_addr); end
  endtask

  task automatic test_flush();
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h0, 32'h13, 1'b0}) begin errors++; $display("FAIL flush_bubble got %h %h %b", if_id_pc, if_id_instr, if_id_valid); end
    checks++; if (imem_addr !== 64'h34 || fetch_count !== 32'd13) begin errors++; $display("FAIL flush_hold got %h cnt %0d want 34/13", imem_addr, fetch_count); end
    step();
    checks++; if (if_id_pc !== 64'h34 || if_id_instr !== 32'h00D00013 || fetch_count !== 32'd14) begin errors++; $display("FAIL flush_refetch got %h %h %0d want 34 00d00013 14", if_id_pc, if_id_instr, fetch_count); end
  endtask

  task automatic test_redirect();
    redir = 1'b1; redir_pc = 64'h43; stall = 1'b1;
    step();
    redir = 1'b0; stall = 1'b0;
    checks++; if (imem_addr !== 64'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin errors++; $display("FAIL redirect got %h %b %h want 40 0 00000013", imem_addr, if_id_valid, if_id_instr); end
    step();
    checks++; if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h40, 32'h06F00913, 1'b1} || fetch_count !== 32'd15) begin errors++; $display("FAIL redirect_target got %h %h %b %0d", if_id_pc, if_id_instr, if_id_valid, fetch_count); end
  endtask

  task automatic test_halt();
    mem[19] = 32'h0000_006F;
    step(); step(); step();
    checks++; if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h4C, 32'h6F, 1'b1}) begin errors++; $display("FAIL halt_capture got %h %h %b", if_id_pc, if_id_instr, if_id_valid); end
    checks++; if (halted !== 1'b1 || imem_addr !== 64'h4C || fetch_count !== 32'd18) begin errors++; $display("FAIL halt_enter got %b %h %0d want 1 4c 18", halted, imem_addr, fetch_count); end
    stall = 1'b1; flush = 1'b1;
    repeat (10) step();
    stall = 1'b0; flush = 1'b0;
    checks++; if (halted !== 1'b1 || imem_addr !== 64'h4C || fetch_count !== 32'd18 || if_id_valid !== 1'b0) begin errors++; $display("FAIL halt_frozen got %b %h %0d %b want 1 4c 18 0", halted, imem_addr, fetch_count, if_id_valid); end
    mem[19] = 32'h0130_0013;
    redir = 1'b1; redir_pc = 64'h0;
    step();
    redir = 1'b0;
    checks++; if (halted !== 1'b0 || imem_addr !== 64'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL halt_resume got %b %h %b want 0 0 0", halted, imem_addr, if_id_valid); end
    step();
    checks++; if (if_id_instr !== 32'h00A00093 || fetch_count !== 32'd19) begin errors++; $display("FAIL halt_resume_fetch got %h %0d want 00a00093 19", if_id_instr, fetch_count); end
  endtask

  task automatic test_fault();
    redir = 1'b1; redir_pc = 64'h7A;
    step();
    redir = 1'b0;
    step(); step();
    checks++; if (imem_addr !== 64'h80 || if_id_pc !== 64'h7C || fetch_count !== 32'd21 || fault !== 1'b0) begin errors++; $display("FAIL fault_edge got %h %h %0d %b want 80 7c 21 0", imem_addr, if_id_pc, fetch_count, fault); end
    step(); step();
    checks++; if (fault !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 64'h80 || fetch_count !== 32'd21) begin errors++; $display("FAIL fault_set got %b %b %h %0d want 1 0 80 21", fault, if_id_valid, imem_addr, fetch_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || imem_addr !== 64'h0 || fetch_count !== 32'd0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL async_reset got %b %h %0d %b want 0 0 0 0", fault, imem_addr, fetch_count, if_id_valid); end
    rst_n = 1'b1;
    step(); step();
    checks++; if (if_id_instr !== 32'h00A00093 || fetch_count !== 32'd1 || fault !== 1'b0) begin errors++; $display("FAIL reboot got %h %0d %b want 00a00093 1 0", if_id_instr, fetch_count, fault); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[0] = 32'h00A0_0093;
    mem[16] = 32'h06F0_0913;
    test_reset();
    test_stall();
    test_flush();
    test_redirect();
    test_halt();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage of the RV64 five-stage pipeline, directly upstream of instruction_memory. It owns the PC and drives the combinational instruction-memory address. It captures the returned word into the IF/ID pipeline register. It also handles stall, flush and branch redirect, detects the end-of-program self-loop (jal x0,0), and flags out-of-range fetches.

Parameters:
RESET_PC, 64'h0, PC loaded at reset
IMEM_BYTES, 128, size of instruction memory in bytes; fetches at or beyond it are faults
HALT_DETECT, 1, 1 = enter HALT on fetching HALT_INSTR

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hazard unit: hold PC and IF/ID (load-use)
flush_i  input  1  replace IF/ID contents with bubble, hold PC
redirect_valid_i  input  1  taken branch/jump resolved downstream
redirect_pc_i  input  64  redirect target
imem_addr_o  output  64  byte address to instruction_memory (= pc register, combinational)
imem_rdata_i  input  32  instruction word from instruction_memory, same cycle
if_id_pc_o  output  64  PC of instruction held in IF/ID
if_id_instr_o  output  32  instruction held in IF/ID
if_id_valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  stage is in HALT
fetch_fault_o  output  1  sticky: out-of-range fetch occurred
fetch_count_o  output  32  number of instructions delivered valid into IF/ID

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR (32'h00000013); if_id_valid=0.
  - halted_o=0; fetch_fault_o=0; fetch_count=0; state=BOOT.
  - Assertion mid-operation clears everything immediately, with no clock needed.
- imem_addr_o = pc at all times. Memory is combinational, so the instruction for pc is captured on the same edge (IF latency 1 cycle).
- States:
  - BOOT: one cycle; IF/ID stays bubble; pc unchanged; -> RUN.
  - RUN: normal fetch, per the priority list below.
  - HALT: pc held, IF/ID bubble, count frozen, halted_o=1.
- Priority each edge in RUN (highest first):
  1. redirect_valid_i: pc <= {redirect_pc_i[63:2],2'b00} (low bits forced to zero); IF/ID <= bubble. Overrides stall and flush.
  2. flush_i: IF/ID <= bubble; pc held (the word at pc is refetched next cycle).
  3. stall_i: pc and IF/ID hold their values.
  4. range fault (pc > IMEM_BYTES-4): IF/ID <= bubble; pc held; fetch_fault_o <= 1 (sticky until reset).
  5. normal: IF/ID <= {pc, imem_rdata_i, valid=1}; pc <= pc+4; fetch_count <= fetch_count+1.
- Halt detect (HALT_DETECT=1, normal case, imem_rdata_i==HALT_INSTR 32'h0000006F):
  - IF/ID captures it valid and count increments.
  - pc is NOT advanced; state -> HALT.
- In HALT:
  - redirect_valid_i -> pc <= target, state -> RUN, IF/ID bubble.
  - stall_i and flush_i are ignored.
- Bubble means instr=NOP_INSTR, valid=0, pc field 0.
- Arithmetic:
  - pc+4 wraps modulo 2^64.
  - fetch_count saturates at 32'hFFFFFFFF.
  - The range check uses an unsigned 64-bit compare.
- Simultaneous redirect+stall: redirect wins; the stalled ID content is squashed.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP_INSTR and HALT_INSTR constants;
  - fetch_state_t enum {BOOT, RUN, HALT};
  - if_id_t packed struct {pc[63:0], instr[31:0], valid}.
- One sub-module: if_id_pipeline_reg. It holds the async-reset register with load/hold/bubble controls and is reused by the ID-stage owner. The PC/FSM logic stays in the top module.

Test Plan:
- Reset then release, memory returning 32'h00A00093 at 0: cycle1 BOOT bubble; cycle2 IF/ID={0,00A00093,1}, imem_addr_o=4; fetch_count=1.
- stall_i high 2 cycles while pc=0x28: imem_addr_o stays 0x28, IF/ID unchanged; after release IF/ID.pc=0x28 next edge.
- redirect_valid_i=1, redirect_pc_i=0x43 together with stall_i=1 at pc=0x38: next pc=0x40, IF/ID valid=0 instr=00000013; the following edge captures 06F00913 at pc 0x40.
- flush_i alone at pc=0x34: IF/ID bubble, pc stays 0x34, count unchanged.
- Fetch 32'h0000006F at pc=0x4C: IF/ID={0x4C,0000006F,1}, halted_o=1 next cycle, pc stays 0x4C, count frozen over 10 cycles; a redirect to 0 resumes RUN.
- pc reaches 0x80 (IMEM_BYTES=128): fetch_fault_o=1, IF/ID bubble, pc held at 0x80; rst_n pulse mid-cycle clears fault, pc=0 asynchronously.
